// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and the read output-stage state encoding.
package fifo_pkg;

  typedef enum logic [1:0] {
    OS_IDLE = 2'd0,
    OS_ONE  = 2'd1,
    OS_TWO  = 2'd2
  } ostage_t;

  function automatic logic [31:0] width_mask(input int unsigned w);
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    logic [31:0] v;
    v = b & width_mask(w);
    return v ^ (v >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] v;
    logic [31:0] b;
    v = g & width_mask(w);
    b = '0;
    for (int i = 0; i < 32; i++) b[i] = ^(v >> i);
    return b;
  endfunction

endpackage

// File: rtl/rptr_handler_if.sv
// Read-side FIFO bundle: write-pointer crossing, RAM read port, status and output stream.
interface rptr_handler_if #(
  parameter int P_PTR_W  = 4,
  parameter int P_DATA_W = 8
);
  logic [P_PTR_W-1:0]  i_g_wptr;
  logic [P_PTR_W-1:0]  o_g_rptr;
  logic                o_r_en;
  logic [P_PTR_W-2:0]  o_r_addr;
  logic [P_DATA_W-1:0] i_r_data;
  logic [P_DATA_W-1:0] o_data;
  logic                o_valid;
  logic                i_ready;
  logic                o_empty;
  logic                o_aempty;
  logic [P_PTR_W-1:0]  o_rlevel;

  modport master (
    input  i_g_wptr, i_r_data, i_ready,
    output o_g_rptr, o_r_en, o_r_addr, o_data, o_valid, o_empty, o_aempty, o_rlevel
  );

  modport slave (
    output i_g_wptr, i_r_data, i_ready,
    input  o_g_rptr, o_r_en, o_r_addr, o_data, o_valid, o_empty, o_aempty, o_rlevel
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a Gray-coded pointer; shared by both FIFO sides.
module sync_ff #(
  parameter int P_WIDTH  = 4,
  parameter int P_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [P_WIDTH-1:0] d,
  output logic [P_WIDTH-1:0] q
);

  logic [P_STAGES-1:0][P_WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[P_STAGES-2:0], d};
  end

  assign q = chain[P_STAGES-1];

endmodule

// File: rtl/rptr_handler.sv
// Read-side FIFO controller: synchronized write pointer, read pointers, status and a
// 2-entry output stage.  state | meaning: IDLE | occ=0, ONE | occ=1, TWO | occ=2
module rptr_handler
  import fifo_pkg::*;
#(
  parameter int P_PTR_W       = 4,
  parameter int P_DATA_W      = 8,
  parameter int P_SYNC_STAGES = 2,
  parameter int P_AEMPTY_TH   = 2
) (
  input  logic          rclk,
  input  logic          rrst_n,
  rptr_handler_if.master bus
);

  localparam logic [P_PTR_W-1:0] AEMPTY_TH = P_PTR_W'(P_AEMPTY_TH);

  logic [P_PTR_W-1:0]  g_wptr_s, b_wptr_s;
  logic [P_PTR_W-1:0]  b_rptr, b_rptr_nxt, g_rptr, g_rptr_nxt, level_nxt, rlevel;
  logic                empty, aempty, r_en, pop;
  logic [P_DATA_W-1:0] out_data, skid_data;
  logic                out_valid, skid_valid, rd_pend;
  ostage_t             state, state_nxt;

  sync_ff #(.P_WIDTH(P_PTR_W), .P_STAGES(P_SYNC_STAGES)) u_sync (
    .clk  (rclk),
    .rst_n(rrst_n),
    .d    (bus.i_g_wptr),
    .q    (g_wptr_s)
  );

  assign b_wptr_s   = P_PTR_W'(gray2bin(32'(g_wptr_s), P_PTR_W));
  assign b_rptr_nxt = b_rptr + P_PTR_W'(r_en);
  assign g_rptr_nxt = P_PTR_W'(bin2gray(32'(b_rptr_nxt), P_PTR_W));
  assign level_nxt  = b_wptr_s - b_rptr_nxt;
  assign pop        = out_valid & bus.i_ready;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr <= '0;
      g_rptr <= '0;
      empty  <= 1'b1;
      aempty <= 1'b1;
      rlevel <= '0;
    end else begin
      b_rptr <= b_rptr_nxt;
      g_rptr <= g_rptr_nxt;
      empty  <= (g_rptr_nxt == g_wptr_s);
      aempty <= (level_nxt <= AEMPTY_TH);
      rlevel <= level_nxt;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= OS_IDLE;
    else         state <= state_nxt;
  end

  // A read may only launch if its data has a guaranteed slot when it returns.
  always_comb begin
    state_nxt = state;
    r_en      = 1'b0;
    case (state)
      OS_IDLE: begin
        r_en = !empty;
        if (r_en) state_nxt = OS_ONE;
      end
      OS_ONE: begin
        r_en = !empty;
        if (r_en && !pop)      state_nxt = OS_TWO;
        else if (!r_en && pop) state_nxt = OS_IDLE;
      end
      OS_TWO: begin
        r_en = !empty && pop;
        if (!r_en && pop) state_nxt = OS_ONE;
      end
      default: state_nxt = OS_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= r_en;
      if (rd_pend && (!out_valid || pop) && !skid_valid) begin
        out_data  <= bus.i_r_data;
        out_valid <= 1'b1;
      end else if (pop && skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= rd_pend;
        if (rd_pend) skid_data <= bus.i_r_data;
      end else if (rd_pend) begin
        skid_data  <= bus.i_r_data;
        skid_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.o_g_rptr = g_rptr;
  assign bus.o_r_en   = r_en;
  assign bus.o_r_addr = b_rptr[P_PTR_W-2:0];
  assign bus.o_data   = out_data;
  assign bus.o_valid  = out_valid;
  assign bus.o_empty  = empty;
  assign bus.o_aempty = aempty;
  assign bus.o_rlevel = rlevel;

endmodule

// File: tb/tb_rptr_handler.sv
// Self-checking bench for rptr_handler: RAM model, write-side stimulus and a data scoreboard.
module tb_rptr_handler;

  logic rclk = 1'b0;
  logic rrst_n = 1'b1;

  rptr_handler_if #(.P_PTR_W(4), .P_DATA_W(8)) bus ();

  rptr_handler #(
    .P_PTR_W(4), .P_DATA_W(8), .P_SYNC_STAGES(2), .P_AEMPTY_TH(2)
  ) dut (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .bus   (bus)
  );

  always #5 rclk = ~rclk;

  logic [7:0] mem [8];
  always @(posedge rclk) if (bus.o_r_en) bus.i_r_data <= mem[bus.o_r_addr];

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];
  logic [2:0] addr_log[$];
  logic [3:0] wb = '0;
  logic [7:0] next_val = 8'h30;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = '0;

  // Stream monitor: scoreboard pops, hold stability and status consistency.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== hold_data) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%b data=%h expected valid=1 data=%h", bus.o_valid, bus.o_data, hold_data);
        end
      end
      n_checks++;
      if (bus.o_empty !== (bus.o_rlevel == 4'd0)) begin
        n_fail++;
        $display("FAIL empty_vs_level: got empty=%b with level=%0d", bus.o_empty, bus.o_rlevel);
      end
      n_checks++;
      if (bus.o_aempty !== (bus.o_rlevel <= 4'd2)) begin
        n_fail++;
        $display("FAIL aempty_vs_level: got aempty=%b with level=%0d", bus.o_aempty, bus.o_rlevel);
      end
      if (bus.o_r_en) addr_log.push_back(bus.o_r_addr);
      if (bus.o_valid && bus.i_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got data=%h expected no beat", bus.o_data);
        end else begin
          logic [7:0] exp_d;
          exp_d = sb_q.pop_front();
          if (bus.o_data !== exp_d) begin
            n_fail++;
            $display("FAIL sb_data: got %h expected %h", bus.o_data, exp_d);
          end
        end
      end
      hold_prev = bus.o_valid && !bus.i_ready;
      hold_data = bus.o_data;
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0;
    bus.i_g_wptr = '0;
    bus.i_ready = 1'b0;
    wb = '0;
    tick();
    tick();
    sb_q.delete();
    addr_log.delete();
    rrst_n = 1'b1;
    tick();
  endtask

  task automatic write_entries(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wb[2:0]] = next_val;
      sb_q.push_back(next_val);
      next_val = next_val + 8'd1;
      wb = wb + 4'd1;
    end
    bus.i_g_wptr = wb ^ (wb >> 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(sb_q.size() == 0 && !bus.o_valid && bus.o_empty) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    bus.i_g_wptr = '0;
    bus.i_ready = 1'b0;
    #2 rrst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.o_empty); end
    n_checks++; if (bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", bus.o_aempty); end
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
    n_checks++; if (bus.o_g_rptr !== 4'b0000) begin n_fail++; $display("FAIL reset_grptr: got %b expected 0000", bus.o_g_rptr); end
    n_checks++; if (bus.o_rlevel !== 4'd0) begin n_fail++; $display("FAIL reset_rlevel: got %0d expected 0", bus.o_rlevel); end
    n_checks++; if (bus.o_r_en !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b expected 0", bus.o_r_en); end
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    bus.i_ready = 1'b1;
    write_entries(1);
    tick();
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL single_e0_empty: got %b expected 1", bus.o_empty); end
    tick();
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL single_e1_empty: got %b expected 1", bus.o_empty); end
    tick();
    n_checks++; if (bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL single_e2_empty: got %b expected 0", bus.o_empty); end
    n_checks++; if (bus.o_r_en !== 1'b1) begin n_fail++; $display("FAIL single_e2_ren: got %b expected 1", bus.o_r_en); end
    n_checks++; if (bus.o_r_addr !== 3'd0) begin n_fail++; $display("FAIL single_e2_addr: got %0d expected 0", bus.o_r_addr); end
    n_checks++; if (bus.o_rlevel !== 4'd1) begin n_fail++; $display("FAIL single_e2_level: got %0d expected 1", bus.o_rlevel); end
    tick();
    n_checks++; if (bus.o_g_rptr !== 4'b0001) begin n_fail++; $display("FAIL single_e3_grptr: got %b expected 0001", bus.o_g_rptr); end
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL single_e3_empty: got %b expected 1", bus.o_empty); end
    n_checks++; if (bus.o_r_en !== 1'b0) begin n_fail++; $display("FAIL single_e3_ren: got %b expected 0", bus.o_r_en); end
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_e3_valid: got %b expected 0", bus.o_valid); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL single_e4_valid: got %b expected 1", bus.o_valid); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_e5_valid: got %b expected 0", bus.o_valid); end
    wait_idle(10);
  endtask

  task automatic test_full_drain();
    int k;
    apply_reset();
    bus.i_ready = 1'b1;
    write_entries(8);
    tick();
    tick();
    tick();
    n_checks++; if (bus.o_rlevel !== 4'd8) begin n_fail++; $display("FAIL full_level: got %0d expected 8", bus.o_rlevel); end
    n_checks++; if (bus.o_aempty !== 1'b0) begin n_fail++; $display("FAIL full_aempty: got %b expected 0", bus.o_aempty); end
    n_checks++; if (bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", bus.o_empty); end
    k = 0;
    while (!bus.o_valid && k < 10) begin tick(); k++; end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL full_beat%0d_valid: got %b expected 1", i, bus.o_valid); end
      tick();
    end
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL full_after_valid: got %b expected 0", bus.o_valid); end
    tick();
    tick();
    n_checks++; if (bus.o_g_rptr !== 4'b1100) begin n_fail++; $display("FAIL full_grptr: got %b expected 1100", bus.o_g_rptr); end
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL full_end_empty: got %b expected 1", bus.o_empty); end
    n_checks++; if (bus.o_rlevel !== 4'd0) begin n_fail++; $display("FAIL full_end_level: got %0d expected 0", bus.o_rlevel); end
    n_checks++; if (addr_log.size() != 8) begin n_fail++; $display("FAIL full_addr_count: got %0d expected 8", addr_log.size()); end
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      n_checks++; if (addr_log[i] !== 3'(i)) begin n_fail++; $display("FAIL full_addr%0d: got %0d expected %0d", i, addr_log[i], i); end
    end
    wait_idle(10);
  endtask

  task automatic test_backpressure();
    int ren_cnt;
    logic [7:0] exp0;
    apply_reset();
    bus.i_ready = 1'b0;
    write_entries(4);
    exp0 = sb_q[0];
    ren_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.o_r_en) ren_cnt++;
    end
    n_checks++; if (ren_cnt != 2) begin n_fail++; $display("FAIL bp_ren_pulses: got %0d expected 2", ren_cnt); end
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", bus.o_valid); end
    n_checks++; if (bus.o_data !== exp0) begin n_fail++; $display("FAIL bp_data: got %h expected %h", bus.o_data, exp0); end
    n_checks++; if (bus.o_rlevel !== 4'd2) begin n_fail++; $display("FAIL bp_level: got %0d expected 2", bus.o_rlevel); end
    bus.i_ready = 1'b1;
    wait_idle(20);
    n_checks++; if (bus.o_rlevel !== 4'd0) begin n_fail++; $display("FAIL bp_end_level: got %0d expected 0", bus.o_rlevel); end
    n_checks++; if (addr_log.size() != 4) begin n_fail++; $display("FAIL bp_addr_count: got %0d expected 4", addr_log.size()); end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_addr [4];
    exp_addr[0] = 3'd6; exp_addr[1] = 3'd7; exp_addr[2] = 3'd0; exp_addr[3] = 3'd1;
    apply_reset();
    bus.i_ready = 1'b1;
    write_entries(7);
    wait_idle(30);
    write_entries(7);
    wait_idle(30);
    tick();
    n_checks++; if (bus.o_g_rptr !== 4'b1001) begin n_fail++; $display("FAIL wrap_start_grptr: got %b expected 1001", bus.o_g_rptr); end
    addr_log.delete();
    write_entries(4);
    n_checks++; if (bus.i_g_wptr !== 4'b0011) begin n_fail++; $display("FAIL wrap_wptr_setup: got %b expected 0011", bus.i_g_wptr); end
    wait_idle(30);
    tick();
    n_checks++; if (addr_log.size() != 4) begin n_fail++; $display("FAIL wrap_addr_count: got %0d expected 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      n_checks++; if (addr_log[i] !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addr_log[i], exp_addr[i]); end
    end
    n_checks++; if (bus.o_g_rptr !== 4'b0011) begin n_fail++; $display("FAIL wrap_grptr: got %b expected 0011", bus.o_g_rptr); end
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b expected 1", bus.o_empty); end
  endtask

  task automatic test_reset_mid();
    int k;
    apply_reset();
    bus.i_ready = 1'b0;
    write_entries(4);
    k = 0;
    while (!bus.o_valid && k < 10) begin tick(); k++; end
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", bus.o_valid); end
    #2 rrst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus.o_valid); end
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b expected 1", bus.o_empty); end
    n_checks++; if (bus.o_aempty !== 1'b1) begin n_fail++; $display("FAIL mid_aempty: got %b expected 1", bus.o_aempty); end
    n_checks++; if (bus.o_g_rptr !== 4'b0000) begin n_fail++; $display("FAIL mid_grptr: got %b expected 0000", bus.o_g_rptr); end
    n_checks++; if (bus.o_rlevel !== 4'd0) begin n_fail++; $display("FAIL mid_rlevel: got %0d expected 0", bus.o_rlevel); end
    n_checks++; if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL mid_data: got %h expected 00", bus.o_data); end
    n_checks++; if (bus.o_r_en !== 1'b0) begin n_fail++; $display("FAIL mid_ren: got %b expected 0", bus.o_r_en); end
    bus.i_g_wptr = '0;
    wb = '0;
    sb_q.delete();
    tick();
    tick();
    rrst_n = 1'b1;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post%0d_valid: got %b expected 0", i, bus.o_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_drain();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
